// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator.
// Operands arrive over a valid/ready handshake and are folded into a redundant
// sum/carry pair (one full-adder level per operand). On the operand flagged
// last, the pair is resolved to binary by iterative carry propagation and the
// result is offered on a valid/ready output port.
// Build option: define CSA_ACC_SAT_EN to saturate out_sum to all ones when the
// group overflowed; otherwise out_sum wraps modulo 2^ACC_W.
module csa_accumulator #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 8   // must be >= DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        StAccum   = 2'd0,
        StResolve = 2'd1,
        StDone    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   maj;
    logic [ACC_W-1:0]   sc;

    // Operand widening and the two carry terms used by ACCUM and RESOLVE.
    always_comb begin
        x   = ACC_W'(in_data);
        maj = (s_q & c_q) | (s_q & x) | (c_q & x);
        sc  = s_q & c_q;
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d   = s_q ^ c_q ^ x;
                    c_d   = maj << 1;
                    // A majority bit at the MSB would carry out of the accumulator.
                    ovf_d = ovf_q | maj[ACC_W-1];
                    if (in_last) begin
                        state_d = StResolve;
                    end
                end
            end

            StResolve: begin
                if (c_q == '0) begin
                    state_d = StDone;
                end else begin
                    s_d   = s_q ^ c_q;
                    c_d   = sc << 1;
                    ovf_d = ovf_q | sc[ACC_W-1];
                end
            end

            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = StAccum;
                end
            end

            default: begin
                state_d = StAccum;
                s_d     = '0;
                c_d     = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Result presentation; zero outside DONE so idle outputs match reset values.
    always_comb begin
        out_sum = '0;
        out_ovf = 1'b0;
        if (state_q == StDone) begin
            out_ovf = ovf_q;
`ifdef CSA_ACC_SAT_EN
            out_sum = ovf_q ? {ACC_W{1'b1}} : s_q;
`else
            out_sum = s_q;
`endif
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (DATA_W=4, ACC_W=8).
module tb_csa_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int n_pass  = 0;
    int n_total = 0;

`ifdef CSA_ACC_SAT_EN
    localparam logic [7:0] OvfSum = 8'd255;
`else
    localparam logic [7:0] OvfSum = 8'd44;   // 300 mod 256
`endif

    csa_accumulator #(
        .DATA_W (4),
        .ACC_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One handshake beat; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for out_valid, sampled on falling edges.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    // out_valid and in_ready must never be high together.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            check("excl", {31'd0, in_ready}, 32'd0);
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {24'd0, out_sum}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);

        // 3+5+7+9 = 24
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd7, 1'b0);
        send(4'd9, 1'b1);
        wait_valid("g1_valid");
        check("g1_sum", {24'd0, out_sum}, 32'd24);
        check("g1_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);
        check("g1_pulse", {31'd0, out_valid}, 32'd0);
        check("g1_ready", {31'd0, in_ready}, 32'd1);

        // Single operand: RESOLVE one cycle, DONE the next
        send(4'hF, 1'b1);
        @(negedge clk);
        check("g2_lat1", {31'd0, out_valid}, 32'd0);
        check("g2_resolve_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("g2_lat2", {31'd0, out_valid}, 32'd1);
        check("g2_sum", {24'd0, out_sum}, 32'd15);
        check("g2_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);

        // 20 x 0xF = 300: overflow, result held while out_ready is low
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(4'hF, (i == 19) ? 1'b1 : 1'b0);
        end
        wait_valid("g3_valid");
        check("g3_sum", {24'd0, out_sum}, {24'd0, OvfSum});
        check("g3_ovf", {31'd0, out_ovf}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {24'd0, out_sum}, {24'd0, OvfSum});
            check("hold_ovf", {31'd0, out_ovf}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_valid", {31'd0, out_valid}, 32'd0);
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        // Accumulator and ovf must be cleared: 1+2 = 3, no overflow
        send(4'd1, 1'b0);
        send(4'd2, 1'b1);
        wait_valid("g4_valid");
        check("g4_sum", {24'd0, out_sum}, 32'd3);
        check("g4_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);

        // Reset mid-group
        send(4'd10, 1'b0);
        send(4'd10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstg_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstg_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstg_out_sum", {24'd0, out_sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during RESOLVE (10+10 leaves a nonzero carry)
        send(4'd10, 1'b0);
        send(4'd10, 1'b1);
        check("rsr_in_resolve", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rsr_in_ready", {31'd0, in_ready}, 32'd1);
        check("rsr_out_valid", {31'd0, out_valid}, 32'd0);
        check("rsr_out_sum", {24'd0, out_sum}, 32'd0);
        check("rsr_out_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rsr_no_output", {31'd0, out_valid}, 32'd0);
        end

        // Fresh single-operand group after reset
        send(4'd4, 1'b1);
        wait_valid("g5_valid");
        check("g5_sum", {24'd0, out_sum}, 32'd4);
        check("g5_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
